// File: rtl/ucdp_sync_hs_src_if.sv
// ucdp_sync_hs_src_if
//   Bundles the handshake and data signals of the source end of a 4-phase
//   req/ack CDC transfer.
//
//   Signals (named from the source block's point of view):
//     valid_i  word on data_i is valid (from the source-side user)
//     ready_o  block can accept a word
//     data_i   word to transfer (DWIDTH bits)
//     req_o    registered request level toward the target domain
//     data_o   registered CDC data bus, frozen for the whole transaction
//     ack_i    acknowledge level from the target domain (asynchronous)
//     busy_o   transaction in flight
//     done_o   one-cycle pulse when a handshake completes
//     err_o    sticky protocol error flag
//
//   Modports:
//     slave   the ucdp_sync_hs_src block itself
//     master  everything around it: the word producer and the target side
interface ucdp_sync_hs_src_if #(
    parameter int unsigned DWIDTH = 8
);
    logic              valid_i;
    logic              ready_o;
    logic [DWIDTH-1:0] data_i;
    logic              req_o;
    logic [DWIDTH-1:0] data_o;
    logic              ack_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    modport slave (
        input  valid_i,
        input  data_i,
        input  ack_i,
        output ready_o,
        output req_o,
        output data_o,
        output busy_o,
        output done_o,
        output err_o
    );

    modport master (
        output valid_i,
        output data_i,
        output ack_i,
        input  ready_o,
        input  req_o,
        input  data_o,
        input  busy_o,
        input  done_o,
        input  err_o
    );
endinterface

// File: rtl/ucdp_sync_hs_src.sv
// ucdp_sync_hs_src
//   Source-domain end of a 4-phase req/ack clock-domain-crossing handshake.
//   A word accepted over valid/ready is captured onto data_o and a level
//   request is raised. The returned acknowledge is synchronised with a
//   SYNC_STAGES-deep flop chain; the request drops once the synchronised
//   ack is seen high, and the transaction completes (done_o pulse) once
//   it is seen low again. data_o is only updated on acceptance, so it is
//   stable for the target domain for the whole transaction.
//
//   Ports:
//     src_clk_i  source clock
//     src_rst_i  asynchronous reset, active-high
//     hs         ucdp_sync_hs_src_if.slave (valid/ready/data in,
//                req/data out, ack in, busy/done/err status out)
//
//   Parameters:
//     DWIDTH       width of the transferred word (1..64)
//     SYNC_STAGES  flops in the ack synchroniser (2..4)
module ucdp_sync_hs_src #(
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic               src_clk_i,
    input logic               src_rst_i,
    ucdp_sync_hs_src_if.slave hs
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ack_s;
    logic              ready;

    // Synchroniser flops for the asynchronous ack level: must stay adjacent
    // and must not be retimed or merged.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] ack_sync_q;

    always_ff @(posedge src_clk_i or posedge src_rst_i) begin
        if (src_rst_i) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], hs.ack_i};
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // Registered-only path: valid_i never feeds ready. Holding ready low while
    // ack_s is high keeps a stale or spurious ack from being mistaken for
    // the acknowledge of a new request.
    assign ready = (state_q == IDLE) && !ack_s;

    always_ff @(posedge src_clk_i or posedge src_rst_i) begin
        if (src_rst_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                // REL only exits once ack_s is low, so any high ack_s seen
                // here was not caused by one of our requests.
                if (ack_s) begin
                    err_d = 1'b1;
                end
                if (hs.valid_i && ready) begin
                    data_d  = hs.data_i;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REL;
                end
            end
            REL: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign hs.ready_o = ready;
    assign hs.req_o   = req_q;
    assign hs.data_o  = data_q;
    assign hs.busy_o  = (state_q != IDLE);
    assign hs.done_o  = done_q;
    assign hs.err_o   = err_q;

endmodule
